// File: rtl/adder_resp_checker_pkg.sv
// Shared definitions for the adder response checker and the benches around it.
// Holds the checker FSM state encoding and helpers that size the coverage map
// and the first-fail capture word from the operand width.
package adder_resp_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // One coverage bit per {a,b,cin} combination.
    function automatic int cov_bits(input int width);
        return 1 << (2 * width + 1);
    endfunction

    // first_fail = {a, b, cin, s, cout}
    function automatic int ff_bits(input int width);
        return 3 * width + 2;
    endfunction

    // Bit offsets of each field inside first_fail (LSB of the field).
    function automatic int ff_off_a(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int ff_off_b(input int width);
        return width + 2;
    endfunction

    function automatic int ff_off_cin(input int width);
        return width + 1;
    endfunction

    function automatic int ff_off_s(input int width);
        return (width > 0) ? 1 : 1;
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden adder: combinational {cout, s} = a + b + cin at WIDTH+1 bits.
// Ports:
//   a, b  in  WIDTH  operands
//   cin   in  1      carry-in
//   s     out WIDTH  sum
//   cout  out 1      carry-out
module adder_ref_model #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign {cout, s} = sum;

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker for the adder family. Registers each applied vector with the
// UUT response, compares it one cycle later against the golden sum, counts
// vectors and mismatches (saturating), captures the first failing vector and
// tracks exhaustive input coverage.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clr          synchronous clear of all checker state (wins over valid)
//   valid        a/b/cin/s/cout carry one applied vector this cycle
//   a, b, cin    stimulus applied to the UUT
//   s, cout      UUT response
//   err          one-cycle pulse per mismatching vector
//   err_cnt      mismatches since reset/clr, saturating
//   vec_cnt      vectors compared since reset/clr, saturating
//   first_fail   {a,b,cin,s,cout} of first mismatch, valid when err_cnt != 0
//   done         every input combination seen; sticky
//   pass         done and no mismatches
//
// state   | meaning
// IDLE    | nothing compared since reset/clr
// RUN     | comparing, coverage map incomplete
// DONE    | coverage map full; still comparing and counting
module adder_resp_checker
    import adder_resp_checker_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    valid,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    cin,
    input  logic [WIDTH-1:0]        s,
    input  logic                    cout,
    output logic                    err,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        vec_cnt,
    output logic [3*WIDTH+1:0]      first_fail,
    output logic                    done,
    output logic                    pass
);

    localparam int COV_BITS = cov_bits(WIDTH);
    localparam int IDX_W    = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_e state_q, state_d;

    logic               s1_vld;
    logic [WIDTH-1:0]   s1_a, s1_b, s1_s;
    logic               s1_cin, s1_cout;

    logic [WIDTH-1:0]   exp_s;
    logic               exp_cout;
    logic               mismatch;
    logic [IDX_W-1:0]   s1_idx;
    logic [COV_BITS-1:0] cov_map, cov_next;
    logic               cov_full_next;

    // Stage 1: capture the applied vector and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_cin  <= 1'b0;
            s1_s    <= '0;
            s1_cout <= 1'b0;
        end else if (clr) begin
            s1_vld  <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_cin  <= 1'b0;
            s1_s    <= '0;
            s1_cout <= 1'b0;
        end else begin
            s1_vld <= valid;
            if (valid) begin
                s1_a    <= a;
                s1_b    <= b;
                s1_cin  <= cin;
                s1_s    <= s;
                s1_cout <= cout;
            end
        end
    end

    adder_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .s    (exp_s),
        .cout (exp_cout)
    );

    assign mismatch      = s1_vld && ({s1_cout, s1_s} != {exp_cout, exp_s});
    assign s1_idx        = {s1_a, s1_b, s1_cin};
    assign cov_next      = s1_vld ? (cov_map | (COV_BITS'(1) << s1_idx)) : cov_map;
    assign cov_full_next = &cov_next;

    // Stage 2: compare results, counters, first-fail capture, coverage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err        <= 1'b0;
            err_cnt    <= '0;
            vec_cnt    <= '0;
            first_fail <= '0;
            cov_map    <= '0;
        end else if (clr) begin
            err        <= 1'b0;
            err_cnt    <= '0;
            vec_cnt    <= '0;
            first_fail <= '0;
            cov_map    <= '0;
        end else begin
            err     <= mismatch;
            cov_map <= cov_next;
            if (s1_vld && vec_cnt != CNT_MAX)
                vec_cnt <= vec_cnt + 1'b1;
            if (mismatch && err_cnt != CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
            // Only the very first mismatch is kept for debug.
            if (mismatch && err_cnt == '0)
                first_fail <= {s1_a, s1_b, s1_cin, s1_s, s1_cout};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else if (clr)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Uses next-cycle coverage so done rises on the edge the last bit is set.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (s1_vld) state_d = cov_full_next ? ST_DONE : ST_RUN;
            ST_RUN:  if (cov_full_next) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign done = (state_q == ST_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_adder_resp_checker.sv
module tb_adder_resp_checker;
    import adder_resp_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, clr2;
    logic       valid;
    logic [1:0] a, b, s;
    logic       cin, cout;

    logic        err;
    logic [15:0] err_cnt, vec_cnt;
    logic [7:0]  first_fail;
    logic        done, pass;

    logic        err2;
    logic [3:0]  err_cnt2, vec_cnt2;
    logic [7:0]  first_fail2;
    logic        done2, pass2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_resp_checker #(.WIDTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .valid(valid),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .err(err), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
        .first_fail(first_fail), .done(done), .pass(pass)
    );

    adder_resp_checker #(.WIDTH(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .valid(valid),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .err(err2), .err_cnt(err_cnt2), .vec_cnt(vec_cnt2),
        .first_fail(first_fail2), .done(done2), .pass(pass2)
    );

    task automatic drive(input logic [1:0] va, input logic [1:0] vb, input logic vc,
                         input logic [1:0] vs, input logic vco);
        @(negedge clk);
        a = va; b = vb; cin = vc; s = vs; cout = vco; valid = 1'b1;
    endtask

    // Correct response for combination i = {a,b,cin}; flip inverts cout.
    task automatic drive_idx(input int i, input logic flip);
        logic [4:0] v;
        logic [2:0] sm;
        v  = i[4:0];
        sm = {1'b0, v[4:3]} + {1'b0, v[2:1]} + {2'b00, v[0]};
        drive(v[4:3], v[2:1], v[0], sm[1:0], sm[2] ^ flip);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0; valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (vec_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_vec_cnt: got %0d want 0", vec_cnt); end
        n_cmp++; if (first_fail !== 8'd0) begin n_fail++; $display("FAIL reset_first_fail: got %b want 0", first_fail); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", pass); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        logic seen;
        seen = 1'b0;
        do_clr();
        for (int i = 0; i < 32; i++) begin
            drive_idx(i, 1'b0);
            seen |= err;
        end
        idle(); seen |= err;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL exh_done_early: got %0b want 0", done); end
        idle(); seen |= err;
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL exh_done: got %0b want 1", done); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL exh_pass: got %0b want 1", pass); end
        n_cmp++; if (vec_cnt !== 16'd32) begin n_fail++; $display("FAIL exh_vec_cnt: got %0d want 32", vec_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL exh_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL exh_err_seen: got %0b want 0", seen); end
    endtask

    task automatic test_fault();
        do_clr();
        drive(2'd3, 2'd1, 1'b1, 2'd1, 1'b0);
        idle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_err_early: got %0b want 0", err); end
        idle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL fault_err: got %0b want 1", err); end
        n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL fault_err_cnt: got %0d want 1", err_cnt); end
        n_cmp++; if (first_fail !== 8'b11_01_1_01_0) begin n_fail++; $display("FAIL fault_first_fail: got %b want 11011010", first_fail); end
        idle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL fault_err_pulse: got %0b want 0", err); end
        drive(2'd0, 2'd0, 1'b1, 2'd0, 1'b0);
        idle();
        idle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL fault2_err: got %0b want 1", err); end
        n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL fault2_err_cnt: got %0d want 2", err_cnt); end
        n_cmp++; if (first_fail !== 8'b11_01_1_01_0) begin n_fail++; $display("FAIL fault2_first_fail: got %b want 11011010", first_fail); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        drive(2'd1, 2'd1, 1'b0, 2'd0, 1'b0);
        drive(2'd2, 2'd3, 1'b1, 2'd2, 1'b0);
        idle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_err1: got %0b want 1", err); end
        n_cmp++; if (first_fail !== 8'b01_01_0_00_0) begin n_fail++; $display("FAIL b2b_first_fail: got %b want 01010000", first_fail); end
        idle();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL b2b_err2: got %0b want 1", err); end
        idle();
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err_end: got %0b want 0", err); end
        n_cmp++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d want 2", err_cnt); end
    endtask

    task automatic test_fault_then_extra();
        do_clr();
        for (int i = 0; i < 32; i++) drive_idx(i, i == 21);
        for (int i = 0; i < 5; i++) drive_idx(i, 1'b0);
        idle();
        idle();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL extra_done: got %0b want 1", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL extra_pass: got %0b want 0", pass); end
        n_cmp++; if (vec_cnt !== 16'd37) begin n_fail++; $display("FAIL extra_vec_cnt: got %0d want 37", vec_cnt); end
        n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL extra_err_cnt: got %0d want 1", err_cnt); end
        n_cmp++; if (first_fail !== 8'b10_10_1_01_0) begin n_fail++; $display("FAIL extra_first_fail: got %b want 10101010", first_fail); end
    endtask

    task automatic test_repeats();
        do_clr();
        for (int i = 0; i < 31; i++) drive_idx(i, 1'b0);
        for (int i = 0; i < 10; i++) drive_idx(i, 1'b0);
        idle();
        idle();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rep_done: got %0b want 0", done); end
        n_cmp++; if (vec_cnt !== 16'd41) begin n_fail++; $display("FAIL rep_vec_cnt: got %0d want 41", vec_cnt); end
        drive_idx(31, 1'b0);
        idle();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rep_done_pre: got %0b want 0", done); end
        idle();
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL rep_done_last: got %0b want 1", done); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL rep_pass: got %0b want 1", pass); end
    endtask

    task automatic test_clr_reset();
        logic seen;
        seen = 1'b0;
        do_clr();
        drive_idx(3, 1'b0);
        drive_idx(7, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; valid = 1'b0; seen |= err;
        idle(); seen |= err;
        idle(); seen |= err;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_err_seen: got %0b want 0", seen); end
        n_cmp++; if (vec_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_vec_cnt: got %0d want 0", vec_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL clr_state: got %0d want 0", dut.state_q); end

        seen = 1'b0;
        drive_idx(5, 1'b0);
        drive_idx(9, 1'b1);
        @(negedge clk);
        n_cmp++; if (vec_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_pre_vec_cnt: got %0d want 1", vec_cnt); end
        rst_n = 1'b0; valid = 1'b0;
        @(negedge clk); seen |= err;
        rst_n = 1'b1;
        idle(); seen |= err;
        idle(); seen |= err;
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_err_seen: got %0b want 0", seen); end
        n_cmp++; if (vec_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_vec_cnt: got %0d want 0", vec_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
        n_cmp++; if (first_fail !== 8'd0) begin n_fail++; $display("FAIL rst_first_fail: got %b want 0", first_fail); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        valid = 1'b0; clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        for (int i = 0; i < 20; i++) drive(2'd0, 2'd0, 1'b0, 2'd1, 1'b0);
        idle();
        idle();
        n_cmp++; if (err_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_err_cnt: got %0d want 15", err_cnt2); end
        n_cmp++; if (vec_cnt2 !== 4'd15) begin n_fail++; $display("FAIL sat_vec_cnt: got %0d want 15", vec_cnt2); end
        n_cmp++; if (first_fail2 !== 8'b00_00_0_01_0) begin n_fail++; $display("FAIL sat_first_fail: got %b want 00000010", first_fail2); end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_fault();
        test_back_to_back();
        test_fault_then_extra();
        test_repeats();
        test_clr_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
